// File: rtl/reglk_pkg.sv
// Shared types and constants for the register-lock access guard.
package reglk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } guard_state_e;

   localparam int REGLK_BITS  = 8;
   localparam int REGLK_IDX_W = 3;

endpackage

// File: rtl/reglk_viol_log.sv
// Violation log: saturating counter, first-offending-address capture and a one-cycle IRQ pulse.
module reglk_viol_log #(
   parameter int ADDR_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  viol_i,
   input  logic                  clr_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [CNT_WIDTH-1:0]  cnt_o,
   output logic                  valid_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  irq_o
);

   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  irq_q;

   // A violation arriving together with a clear restarts the log with itself as the first entry.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      if (viol_i) begin
         if (clr_i) begin
            cnt_d = CNT_WIDTH'(1);
         end else if (~&cnt_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
         if (clr_i || !valid_q) begin
            addr_d  = addr_i;
            valid_d = 1'b1;
         end
      end else if (clr_i) begin
         cnt_d   = '0;
         valid_d = 1'b0;
         addr_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         irq_q   <= viol_i;
      end
   end

   assign cnt_o   = cnt_q;
   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign irq_o   = irq_q;

endmodule

// File: rtl/reglk_access_guard.sv
// Guards a peripheral register file: blocks writes to locked registers, errors out-of-range
// accesses and logs lock violations.
module reglk_access_guard
   import reglk_pkg::*;
#(
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 64,
   parameter int NUM_REGS    = 8,
   parameter int REG_IDX_LSB = 3,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [REGLK_BITS-1:0]  reglk_i,
   input  logic                   jtag_unlock,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_we_i,
   input  logic [ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [DATA_WIDTH-1:0]  req_wdata_i,
   output logic                   per_valid_o,
   input  logic                   per_ready_i,
   output logic                   per_we_o,
   output logic [REGLK_IDX_W-1:0] per_idx_o,
   output logic [DATA_WIDTH-1:0]  per_wdata_o,
   input  logic [DATA_WIDTH-1:0]  per_rdata_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic                   rsp_err_o,
   output logic [DATA_WIDTH-1:0]  rsp_rdata_o,
   input  logic                   viol_clr_i,
   output logic [CNT_WIDTH-1:0]   viol_cnt_o,
   output logic                   viol_valid_o,
   output logic [ADDR_WIDTH-1:0]  viol_addr_o,
   output logic                   irq_o
);

   guard_state_e           state_q;
   logic                   per_valid_q, rsp_valid_q;
   logic                   we_q, err_q;
   logic [REGLK_IDX_W-1:0] idx_q;
   logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;

   logic [REGLK_IDX_W-1:0] idx_w;
   logic                   accept_w, out_of_range_w, locked_w, viol_w;
   logic                   addr_lsb_unused;

   // Byte-offset bits below the register index carry no meaning for this register file.
   assign addr_lsb_unused = ^req_addr_i[REG_IDX_LSB-1:0];

   assign req_ready_o    = (state_q == IDLE) && !rst_i;
   assign accept_w       = req_valid_i && req_ready_o;
   assign idx_w          = req_addr_i[REG_IDX_LSB +: REGLK_IDX_W];
   assign out_of_range_w = (|req_addr_i[ADDR_WIDTH-1:REG_IDX_LSB+REGLK_IDX_W]) ||
                           (int'(idx_w) >= NUM_REGS);
   assign locked_w       = req_we_i && reglk_i[idx_w] && !jtag_unlock;
   assign viol_w         = accept_w && !out_of_range_w && locked_w;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         per_valid_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         we_q        <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_w) begin
                  we_q    <= req_we_i;
                  idx_q   <= idx_w;
                  wdata_q <= req_wdata_i;
                  if (out_of_range_w || locked_w) begin
                     err_q       <= 1'b1;
                     rdata_q     <= '0;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end else begin
                     per_valid_q <= 1'b1;
                     state_q     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (per_ready_i) begin
                  per_valid_q <= 1'b0;
                  err_q       <= 1'b0;
                  rdata_q     <= we_q ? '0 : per_rdata_i;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               per_valid_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign per_valid_o = per_valid_q;
   assign per_we_o    = we_q;
   assign per_idx_o   = idx_q;
   assign per_wdata_o = wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = err_q;
   assign rsp_rdata_o = rdata_q;

   reglk_viol_log #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_viol_log (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .viol_i  (viol_w),
      .clr_i   (viol_clr_i),
      .addr_i  (req_addr_i),
      .cnt_o   (viol_cnt_o),
      .valid_o (viol_valid_o),
      .addr_o  (viol_addr_o),
      .irq_o   (irq_o)
   );

endmodule

// File: tb/tb_reglk_access_guard.sv
// Bench for reglk_access_guard: a default instance and a NUM_REGS=6 / CNT_WIDTH=2 instance.
module tb_reglk_access_guard;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  reglk;
   logic        jtag;
   logic        req_valid, req_we, per_ready, rsp_ready, viol_clr;
   logic [63:0] req_addr, req_wdata, per_rdata;
   bit          sel;

   logic        a_req_ready, a_per_valid, a_per_we, a_rsp_valid, a_rsp_err, a_vv, a_irq;
   logic [2:0]  a_per_idx;
   logic [63:0] a_per_wdata, a_rsp_rdata, a_va;
   logic [15:0] a_cnt;
   logic        b_req_ready, b_per_valid, b_per_we, b_rsp_valid, b_rsp_err, b_vv, b_irq;
   logic [2:0]  b_per_idx;
   logic [63:0] b_per_wdata, b_rsp_rdata, b_va;
   logic [1:0]  b_cnt;

   logic        o_req_ready, o_per_valid, o_per_we, o_rsp_valid, o_rsp_err, o_vv, o_irq;
   logic [2:0]  o_per_idx;
   logic [63:0] o_per_wdata, o_rsp_rdata, o_va;
   logic [15:0] o_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // reference log state per instance
   int          m_cnt   [2];
   logic        m_vld   [2];
   logic [63:0] m_addr  [2];
   int          m_max   [2] = '{65535, 3};
   int          m_nregs [2] = '{8, 6};

   always #5 clk = ~clk;

   reglk_access_guard u_dut_a (
      .clk_i(clk), .rst_i(rst), .reglk_i(reglk), .jtag_unlock(jtag),
      .req_valid_i(req_valid & ~sel), .req_ready_o(a_req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .per_valid_o(a_per_valid), .per_ready_i(per_ready), .per_we_o(a_per_we),
      .per_idx_o(a_per_idx), .per_wdata_o(a_per_wdata), .per_rdata_i(per_rdata),
      .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(a_rsp_err),
      .rsp_rdata_o(a_rsp_rdata), .viol_clr_i(viol_clr & ~sel), .viol_cnt_o(a_cnt),
      .viol_valid_o(a_vv), .viol_addr_o(a_va), .irq_o(a_irq)
   );

   reglk_access_guard #(.NUM_REGS(6), .CNT_WIDTH(2)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .reglk_i(reglk), .jtag_unlock(jtag),
      .req_valid_i(req_valid & sel), .req_ready_o(b_req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .per_valid_o(b_per_valid), .per_ready_i(per_ready), .per_we_o(b_per_we),
      .per_idx_o(b_per_idx), .per_wdata_o(b_per_wdata), .per_rdata_i(per_rdata),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(b_rsp_err),
      .rsp_rdata_o(b_rsp_rdata), .viol_clr_i(viol_clr & sel), .viol_cnt_o(b_cnt),
      .viol_valid_o(b_vv), .viol_addr_o(b_va), .irq_o(b_irq)
   );

   always_comb begin
      if (!sel) begin
         o_req_ready = a_req_ready; o_per_valid = a_per_valid; o_per_we = a_per_we;
         o_per_idx = a_per_idx; o_per_wdata = a_per_wdata; o_rsp_valid = a_rsp_valid;
         o_rsp_err = a_rsp_err; o_rsp_rdata = a_rsp_rdata; o_cnt = a_cnt;
         o_vv = a_vv; o_va = a_va; o_irq = a_irq;
      end else begin
         o_req_ready = b_req_ready; o_per_valid = b_per_valid; o_per_we = b_per_we;
         o_per_idx = b_per_idx; o_per_wdata = b_per_wdata; o_rsp_valid = b_rsp_valid;
         o_rsp_err = b_rsp_err; o_rsp_rdata = b_rsp_rdata; o_cnt = {14'd0, b_cnt};
         o_vv = b_vv; o_va = b_va; o_irq = b_irq;
      end
   end

   // 0 = passes to the peripheral, 1 = out of range, 2 = lock violation
   function automatic int exp_kind(input logic we, input logic [63:0] a, input logic [7:0] lk,
                                   input logic jt, input int nregs);
      int idx;
      idx = int'((a / 8) % 8);
      if ((a / 64) != 0 || idx >= nregs) return 1;
      if (we && lk[idx] && !jt) return 2;
      return 0;
   endfunction

   task automatic apply_reset();
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      per_ready = 1'b0; rsp_ready = 1'b0; viol_clr = 1'b0; per_rdata = '0;
      reglk = '0; jtag = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_vld[i] = 1'b0; m_addr[i] = '0;
      end
   endtask

   // Drives one request through the selected instance and records what it observed.
   task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] prd, input logic [7:0] lock, input int per_dly,
                          input int rsp_dly, input logic clr,
                          output logic err, output logic [63:0] rdata, output int per_seen,
                          output logic [2:0] pidx, output logic pwe, output logic [63:0] pwd,
                          output int irqs, output int bad, output logic to);
      int   rsp_seen;
      logic rsp_hs;
      int   wait_cyc;
      per_seen = 0; rsp_seen = 0; irqs = 0; bad = 0; to = 1'b1; rsp_hs = 1'b0;
      err = 1'bx; rdata = 'x; pidx = 'x; pwe = 1'bx; pwd = 'x;
      reglk = lock; req_we = we; req_addr = addr; req_wdata = wdata; per_rdata = prd;
      viol_clr = clr; req_valid = 1'b1; per_ready = 1'b0; rsp_ready = 1'b0;
      wait_cyc = 0;
      while (!o_req_ready && wait_cyc < 20) begin
         @(posedge clk); #1; wait_cyc++;
      end
      if (!o_req_ready) begin
         req_valid = 1'b0; viol_clr = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0; viol_clr = 1'b0; reglk = 8'($urandom);
      for (int c = 0; c < 60; c++) begin
         if (o_irq) irqs++;
         if (rsp_hs) begin
            if (o_rsp_valid || !o_req_ready) bad++;
            to = 1'b0;
            break;
         end
         if (o_req_ready) bad++;
         if (o_per_valid) begin
            per_seen++;
            if (per_seen == 1) begin
               pidx = o_per_idx; pwe = o_per_we; pwd = o_per_wdata;
            end else if (pidx !== o_per_idx || pwe !== o_per_we || pwd !== o_per_wdata) begin
               bad++;
            end
            per_ready = (per_seen > per_dly);
         end else begin
            per_ready = 1'b0;
         end
         if (o_rsp_valid) begin
            rsp_seen++;
            if (rsp_seen == 1) begin
               err = o_rsp_err; rdata = o_rsp_rdata;
            end else if (err !== o_rsp_err || rdata !== o_rsp_rdata) begin
               bad++;
            end
            if (rsp_seen > rsp_dly) begin
               rsp_ready = 1'b1; rsp_hs = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      per_ready = 1'b0; rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int s = 0; s < 2; s++) begin
         sel = s[0]; #1;
         n_cmp++;
         if (o_req_ready !== 1'b1 || o_per_valid !== 1'b0 || o_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl inst%0d: ready=%b per_valid=%b rsp_valid=%b, want 1 0 0",
                     s, o_req_ready, o_per_valid, o_rsp_valid);
         end
         n_cmp++;
         if (o_cnt !== 16'd0 || o_vv !== 1'b0 || o_va !== 64'd0 || o_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_log inst%0d: cnt=%0d valid=%b addr=%h irq=%b, want all zero",
                     s, o_cnt, o_vv, o_va, o_irq);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_lock_basic();
      logic err, pwe, to; logic [63:0] rd, pwd; logic [2:0] pidx; int ps, irqs, bad;
      sel = 1'b0; jtag = 1'b0;
      run_txn(1'b1, 64'h10, 64'hDEAD, 64'h0, 8'h00, 0, 0, 1'b0,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (ps !== 1 || pidx !== 3'd2 || pwe !== 1'b1 || pwd !== 64'hDEAD) begin
         n_bad++;
         $display("FAIL unlocked_write_per: seen=%0d idx=%0d we=%b wdata=%h, want 1 2 1 dead",
                  ps, pidx, pwe, pwd);
      end
      n_cmp++;
      if (err !== 1'b0 || rd !== 64'd0 || o_cnt !== 16'd0 || irqs !== 0 || bad !== 0 || to) begin
         n_bad++;
         $display("FAIL unlocked_write_rsp: err=%b rdata=%h cnt=%0d irqs=%0d bad=%0d to=%b, want 0 0 0 0 0 0",
                  err, rd, o_cnt, irqs, bad, to);
      end
      run_txn(1'b1, 64'h10, 64'hBEEF, 64'h0, 8'h04, 0, 0, 1'b0,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (ps !== 0 || err !== 1'b1 || rd !== 64'd0 || to) begin
         n_bad++;
         $display("FAIL locked_write_rsp: seen=%0d err=%b rdata=%h to=%b, want 0 1 0 0", ps, err, rd, to);
      end
      n_cmp++;
      if (o_cnt !== 16'd1 || o_vv !== 1'b1 || o_va !== 64'h10 || irqs !== 1) begin
         n_bad++;
         $display("FAIL locked_write_log: cnt=%0d valid=%b addr=%h irqs=%0d, want 1 1 10 1",
                  o_cnt, o_vv, o_va, irqs);
      end
      jtag = 1'b1;
      run_txn(1'b1, 64'h10, 64'h55, 64'h0, 8'h04, 0, 0, 1'b0,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (ps !== 1 || err !== 1'b0 || o_cnt !== 16'd1 || irqs !== 0 || to) begin
         n_bad++;
         $display("FAIL jtag_unlock: seen=%0d err=%b cnt=%0d irqs=%0d to=%b, want 1 0 1 0 0",
                  ps, err, o_cnt, irqs, to);
      end
      jtag = 1'b0;
      run_txn(1'b0, 64'h38, 64'h0, 64'h1234, 8'hFF, 0, 0, 1'b0,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (ps !== 1 || pidx !== 3'd7 || pwe !== 1'b0 || err !== 1'b0 || rd !== 64'h1234 || to) begin
         n_bad++;
         $display("FAIL locked_read: seen=%0d idx=%0d we=%b err=%b rdata=%h, want 1 7 0 0 1234",
                  ps, pidx, pwe, err, rd);
      end
   endtask

   task automatic test_range();
      logic err, pwe, to; logic [63:0] rd, pwd; logic [2:0] pidx; int ps, irqs, bad;
      apply_reset();
      sel = 1'b1; #1;
      run_txn(1'b0, 64'h30, 64'h0, 64'h77, 8'h00, 0, 0, 1'b0,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (ps !== 0 || err !== 1'b1 || rd !== 64'd0 || o_cnt !== 16'd0 || irqs !== 0 || to) begin
         n_bad++;
         $display("FAIL range_idx6: seen=%0d err=%b rdata=%h cnt=%0d irqs=%0d, want 0 1 0 0 0",
                  ps, err, rd, o_cnt, irqs);
      end
      run_txn(1'b1, 64'h100, 64'h9, 64'h0, 8'hFF, 0, 0, 1'b0,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (ps !== 0 || err !== 1'b1 || o_cnt !== 16'd0 || o_vv !== 1'b0 || to) begin
         n_bad++;
         $display("FAIL range_high_addr: seen=%0d err=%b cnt=%0d valid=%b, want 0 1 0 0",
                  ps, err, o_cnt, o_vv);
      end
      run_txn(1'b0, 64'h28, 64'h0, 64'hA5, 8'hFF, 0, 0, 1'b0,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (ps !== 1 || pidx !== 3'd5 || err !== 1'b0 || rd !== 64'hA5 || to) begin
         n_bad++;
         $display("FAIL range_last_reg: seen=%0d idx=%0d err=%b rdata=%h, want 1 5 0 a5",
                  ps, pidx, err, rd);
      end
   endtask

   task automatic test_saturate();
      logic err, pwe, to; logic [63:0] rd, pwd; logic [2:0] pidx; int ps, irqs, bad, tot_irq;
      apply_reset();
      sel = 1'b1; #1;
      tot_irq = 0;
      for (int k = 1; k <= 5; k++) begin
         run_txn(1'b1, 64'(k * 8), 64'h1, 64'h0, 8'hFF, 0, 0, 1'b0,
                 err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
         tot_irq += irqs;
      end
      n_cmp++;
      if (o_cnt !== 16'd3 || o_vv !== 1'b1 || o_va !== 64'h08 || tot_irq !== 5) begin
         n_bad++;
         $display("FAIL saturate: cnt=%0d valid=%b addr=%h irqs=%0d, want 3 1 8 5",
                  o_cnt, o_vv, o_va, tot_irq);
      end
      run_txn(1'b1, 64'h20, 64'h1, 64'h0, 8'hFF, 0, 0, 1'b1,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (o_cnt !== 16'd1 || o_vv !== 1'b1 || o_va !== 64'h20 || irqs !== 1 || err !== 1'b1) begin
         n_bad++;
         $display("FAIL clear_with_viol: cnt=%0d valid=%b addr=%h irqs=%0d err=%b, want 1 1 20 1 1",
                  o_cnt, o_vv, o_va, irqs, err);
      end
      viol_clr = 1'b1;
      @(posedge clk); #1;
      viol_clr = 1'b0;
      n_cmp++;
      if (o_cnt !== 16'd0 || o_vv !== 1'b0 || o_va !== 64'd0 || o_irq !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_alone: cnt=%0d valid=%b addr=%h irq=%b, want 0 0 0 0",
                  o_cnt, o_vv, o_va, o_irq);
      end
   endtask

   task automatic test_backpressure();
      logic err, pwe, to; logic [63:0] rd, pwd; logic [2:0] pidx; int ps, irqs, bad;
      sel = 1'b0; #1;
      run_txn(1'b1, 64'h18, 64'hCAFE, 64'h0, 8'h00, 5, 4, 1'b0,
              err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
      n_cmp++;
      if (ps !== 6 || pidx !== 3'd3 || pwd !== 64'hCAFE || err !== 1'b0 || bad !== 0 || to) begin
         n_bad++;
         $display("FAIL backpressure: seen=%0d idx=%0d wdata=%h err=%b unstable=%0d to=%b, want 6 3 cafe 0 0 0",
                  ps, pidx, pwd, err, bad, to);
      end
   endtask

   task automatic test_reset_mid();
      sel = 1'b0; #1;
      reglk = 8'h00; req_we = 1'b1; req_addr = 64'h08; req_wdata = 64'h3; req_valid = 1'b1;
      per_ready = 1'b0; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_cmp++;
      if (o_per_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_issue: per_valid=%b, want 1", o_per_valid);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (o_per_valid !== 1'b0 || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset: per_valid=%b rsp_valid=%b ready=%b, want 0 0 0",
                  o_per_valid, o_rsp_valid, o_req_ready);
      end
      rst = 1'b0; #1;
      n_cmp++;
      if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_release: ready=%b rsp_valid=%b, want 1 0", o_req_ready, o_rsp_valid);
      end
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_vld[i] = 1'b0; m_addr[i] = '0;
      end
   endtask

   task automatic test_random();
      logic err, pwe, to; logic [63:0] rd, pwd; logic [2:0] pidx; int ps, irqs, bad;
      logic we, clr; logic [63:0] addr, wd, prd; logic [7:0] lk; int pdl, rdl, kind, s;
      logic [63:0] e_rd;
      apply_reset();
      for (int t = 0; t < 150; t++) begin
         sel = 1'($urandom_range(0, 1)); #1;
         s = sel ? 1 : 0;
         we = 1'($urandom); lk = 8'($urandom); jtag = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 7) == 0);
         wd = {$urandom, $urandom}; prd = {$urandom, $urandom};
         pdl = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0)
            addr = (64'd1 << $urandom_range(6, 63)) | 64'($urandom_range(0, 63));
         else
            addr = 64'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
         kind = exp_kind(we, addr, lk, jtag, m_nregs[s]);
         run_txn(we, addr, wd, prd, lk, pdl, rdl, clr, err, rd, ps, pidx, pwe, pwd, irqs, bad, to);
         if (kind == 2) begin
            m_cnt[s] = clr ? 1 : ((m_cnt[s] < m_max[s]) ? m_cnt[s] + 1 : m_cnt[s]);
            if (clr || !m_vld[s]) begin
               m_vld[s] = 1'b1; m_addr[s] = addr;
            end
         end else if (clr) begin
            m_cnt[s] = 0; m_vld[s] = 1'b0; m_addr[s] = '0;
         end
         e_rd = (kind == 0 && !we) ? prd : 64'd0;
         n_cmp++;
         if (err !== (kind != 0) || rd !== e_rd || bad !== 0 || to) begin
            n_bad++;
            $display("FAIL rnd_rsp t=%0d: err=%b rdata=%h unstable=%0d to=%b, want %b %h 0 0",
                     t, err, rd, bad, to, kind != 0, e_rd);
         end
         n_cmp++;
         if (kind == 0 ? (ps !== pdl + 1 || pidx !== 3'((addr / 8) % 8) || pwe !== we ||
                          (we && pwd !== wd)) : (ps !== 0)) begin
            n_bad++;
            $display("FAIL rnd_per t=%0d: seen=%0d idx=%0d we=%b wdata=%h, want seen=%0d idx=%0d we=%b wdata=%h",
                     t, ps, pidx, pwe, pwd, (kind == 0) ? pdl + 1 : 0, (addr / 8) % 8, we, wd);
         end
         n_cmp++;
         if (o_cnt !== 16'(m_cnt[s]) || o_vv !== m_vld[s] || o_va !== m_addr[s] ||
             irqs !== ((kind == 2) ? 1 : 0)) begin
            n_bad++;
            $display("FAIL rnd_log t=%0d: cnt=%0d valid=%b addr=%h irqs=%0d, want %0d %b %h %0d",
                     t, o_cnt, o_vv, o_va, irqs, m_cnt[s], m_vld[s], m_addr[s], (kind == 2) ? 1 : 0);
         end
      end
      jtag = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
      test_reset();
      test_lock_basic();
      test_backpressure();
      test_reset_mid();
      test_range();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
